// File: rtl/crossbar_pkg.sv
// Shared types and sizing helpers for the PMU event crossbar configuration block.
package crossbar_pkg;

    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_REVERT  = 1;
    localparam int unsigned CTRL_PENDING = 2;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    function automatic int unsigned fields_per_word(input int unsigned n_in,
                                                    input int unsigned reg_width);
        return reg_width / $clog2(n_in);
    endfunction

    function automatic int unsigned n_words(input int unsigned n_out,
                                            input int unsigned n_in,
                                            input int unsigned reg_width);
        int unsigned fpw;
        fpw = fields_per_word(n_in, reg_width);
        return (n_out + fpw - 1) / fpw;
    endfunction

endpackage

// File: rtl/crossbar_cfg_field_chk.sv
// Per-word field checker: flags out-of-range selectors and marks which fields map to real counters.
module crossbar_cfg_field_chk
    import crossbar_pkg::*;
#(
    parameter  int unsigned N_OUT           = 24,
    parameter  int unsigned N_IN            = 32,
    parameter  int unsigned REG_WIDTH       = 32,
    localparam int unsigned N_BITS_CFG      = $clog2(N_IN),
    localparam int unsigned FIELDS_PER_WORD = fields_per_word(N_IN, REG_WIDTH),
    localparam int unsigned N_WORDS         = n_words(N_OUT, N_IN, REG_WIDTH),
    localparam int unsigned ADDR_W          = $clog2(N_WORDS + 1)
) (
    input  logic [REG_WIDTH-1:0]       data,
    input  logic [ADDR_W-1:0]          word,
    output logic                       legal,
    output logic [FIELDS_PER_WORD-1:0] mask
);

    // Leftover bits above the last whole field carry no meaning.
    logic unused_data;
    assign unused_data = ^data;

    always_comb begin
        legal = 1'b1;
        mask  = '0;
        for (int unsigned k = 0; k < FIELDS_PER_WORD; k++) begin
            if (32'(word) * FIELDS_PER_WORD + k < N_OUT) begin
                mask[k] = 1'b1;
                if (32'(data[k*N_BITS_CFG +: N_BITS_CFG]) >= N_IN) begin
                    legal = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/crossbar_cfg_regs.sv
// Register front end for the PMU event crossbar: shadow/active selector banks with atomic commit.
module crossbar_cfg_regs
    import crossbar_pkg::*;
#(
    parameter  int unsigned N_OUT           = 24,
    parameter  int unsigned N_IN            = 32,
    parameter  int unsigned REG_WIDTH       = 32,
    localparam int unsigned N_BITS_CFG      = $clog2(N_IN),
    localparam int unsigned FIELDS_PER_WORD = fields_per_word(N_IN, REG_WIDTH),
    localparam int unsigned N_WORDS         = n_words(N_OUT, N_IN, REG_WIDTH),
    localparam int unsigned ADDR_W          = $clog2(N_WORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [REG_WIDTH-1:0]  req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [REG_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [N_BITS_CFG-1:0] cfg_o [N_OUT],
    output logic                  cfg_pending_o
);

    localparam int unsigned CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                 state, state_nx;
    logic [N_BITS_CFG-1:0]  shadow    [N_OUT];
    logic [N_BITS_CFG-1:0]  shadow_nx [N_OUT];
    logic [N_BITS_CFG-1:0]  active    [N_OUT];
    logic [N_BITS_CFG-1:0]  active_nx [N_OUT];
    logic                   pending, pending_nx;
    logic [REG_WIDTH-1:0]   rdata, rdata_nx;
    logic                   err, err_nx;
    logic                   legal;
    logic [FIELDS_PER_WORD-1:0] mask;
    logic                   accept, is_cfg, is_ctrl;
    logic [CNT_W-1:0]       idx;

    crossbar_cfg_field_chk #(
        .N_OUT     (N_OUT),
        .N_IN      (N_IN),
        .REG_WIDTH (REG_WIDTH)
    ) u_field_chk (
        .data  (req_wdata_i),
        .word  (req_addr_i),
        .legal (legal),
        .mask  (mask)
    );

    always_comb begin
        state_nx    = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nx = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept  = req_valid_i & req_ready_o;
    assign is_cfg  = 32'(req_addr_i) < N_WORDS;
    assign is_ctrl = 32'(req_addr_i) == N_WORDS;

    // Next bank contents and response are resolved in one pass so they all land on the accept edge.
    always_comb begin
        shadow_nx = shadow;
        active_nx = active;
        rdata_nx  = '0;
        err_nx    = 1'b0;
        idx       = '0;
        if (is_cfg) begin
            if (req_we_i && !legal) begin
                err_nx = 1'b1;
            end else begin
                for (int unsigned k = 0; k < FIELDS_PER_WORD; k++) begin
                    idx = CNT_W'(32'(req_addr_i) * FIELDS_PER_WORD + k);
                    if (mask[k]) begin
                        if (req_we_i) shadow_nx[idx] = req_wdata_i[k*N_BITS_CFG +: N_BITS_CFG];
                        else          rdata_nx[k*N_BITS_CFG +: N_BITS_CFG] = shadow[idx];
                    end
                end
            end
        end else if (is_ctrl) begin
            if (req_we_i) begin
                if (req_wdata_i[CTRL_COMMIT] && req_wdata_i[CTRL_REVERT]) err_nx = 1'b1;
                else if (req_wdata_i[CTRL_COMMIT])                       active_nx = shadow;
                else if (req_wdata_i[CTRL_REVERT])                       shadow_nx = active;
            end else begin
                rdata_nx[CTRL_PENDING] = pending;
            end
        end else begin
            err_nx = 1'b1;
        end
    end

    always_comb begin
        pending_nx = 1'b0;
        for (int unsigned c = 0; c < N_OUT; c++) begin
            if (shadow_nx[c] != active_nx[c]) pending_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            pending <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            for (int unsigned c = 0; c < N_OUT; c++) begin
                shadow[c] <= '0;
                active[c] <= '0;
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                shadow  <= shadow_nx;
                active  <= active_nx;
                pending <= pending_nx;
                rdata   <= rdata_nx;
                err     <= err_nx;
            end
        end
    end

    assign cfg_o         = active;
    assign cfg_pending_o = pending;
    assign rsp_rdata_o   = rdata;
    assign rsp_err_o     = err;

endmodule
